// File: rtl/prim_skid_slice.sv
// prim_skid_slice -- two-entry valid/ready register slice (skid buffer).
//
// Registers both the forward path (valid/data) and the reverse path (ready)
// between a producer and a consumer without losing or duplicating beats.
// The main register drives out_data_o. The skid register absorbs the one beat
// that arrives after the consumer stalls.
//
// Parameters:
//   Width       data path width in bits (>= 1)
//   ResetValue  reset value of the main and skid data registers
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous flush; discards all held entries
//   in_valid_i   upstream data valid
//   in_ready_o   slice can accept data (decoded from state flops)
//   in_data_i    upstream data
//   out_valid_o  slice holds data for downstream (decoded from state flops)
//   out_ready_i  downstream accepts data
//   out_data_o   data presented downstream (main register)
//   occ_o        entry count 0..2; present only when PRIM_SKID_SLICE_OCC_EN
//                is defined
//
// Optional feature macro: PRIM_SKID_SLICE_OCC_EN

module prim_skid_slice #(
    parameter int unsigned       Width      = 32,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
`ifdef PRIM_SKID_SLICE_OCC_EN
    ,
    output logic [1:0]       occ_o
`endif
);

    // The encoding equals the entry count, so occ_o is the state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q;
    logic [Width-1:0] main_q;
    logic [Width-1:0] skid_q;
    logic             in_xfer;
    logic             out_xfer;

    // Both handshake outputs decode the state flops only. No input reaches
    // them combinationally.
    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = (state_q != FULL);
    assign out_data_o  = main_q;

    assign in_xfer  = in_valid_i  & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= ResetValue;
            skid_q  <= ResetValue;
        end else if (flush_i) begin
            // Data registers keep stale contents. They are masked by out_valid_o=0.
            state_q <= EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_q <= ONE;
                        main_q  <= in_data_i;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data_i;
                    end else if (in_xfer) begin
                        // The consumer stalled. Park the new beat behind main.
                        state_q <= FULL;
                        skid_q  <= in_data_i;
                    end else if (out_xfer) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef PRIM_SKID_SLICE_OCC_EN
    assign occ_o = state_q;
`endif

endmodule

// File: tb/tb_prim_skid_slice.sv
// tb_prim_skid_slice -- directed self-checking bench for prim_skid_slice.
// Width=32, ResetValue=32'hDEAD_BEEF. Inputs are driven, and outputs sampled,
// 1ns after each rising edge. occ_o is checked only when PRIM_SKID_SLICE_OCC_EN
// is defined.

module tb_prim_skid_slice;

    localparam int unsigned      W  = 32;
    localparam logic [W-1:0]     RV = 32'hDEAD_BEEF;

    logic         clk_i;
    logic         rst_ni;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] out_data_o;
`ifdef PRIM_SKID_SLICE_OCC_EN
    logic [1:0]   occ_o;
`endif

    int n_checks;
    int n_fail;

    prim_skid_slice #(
        .Width      (W),
        .ResetValue (RV)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
`ifdef PRIM_SKID_SLICE_OCC_EN
        ,
        .occ_o       (occ_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 32'h1234_5678;
        out_ready_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o);
        end
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o);
        end
        n_checks++;
        if (out_data_o !== RV) begin
            n_fail++; $display("FAIL reset_out_data: got %h expected %h", out_data_o, RV);
        end
`ifdef PRIM_SKID_SLICE_OCC_EN
        n_checks++;
        if (occ_o !== 2'd0) begin
            n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ_o);
        end
`endif
    endtask

    task automatic test_streaming();
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        for (int unsigned k = 1; k <= 4; k++) begin
            in_data_i = k;
            tick();
            n_checks++;
            if (out_valid_o !== 1'b1) begin
                n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, out_valid_o);
            end
            n_checks++;
            if (out_data_o !== W'(k)) begin
                n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", k, out_data_o, k);
            end
            n_checks++;
            if (in_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, in_ready_o);
            end
`ifdef PRIM_SKID_SLICE_OCC_EN
            n_checks++;
            if (occ_o !== 2'd1) begin
                n_fail++; $display("FAIL stream_occ[%0d]: got %0d expected 1", k, occ_o);
            end
`endif
        end
        in_valid_i = 1'b0;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL stream_drain: got %b expected 0", out_valid_o);
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hA;
        tick();
        n_checks++;
        if (out_data_o !== 32'hA || out_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_a: got v=%b d=%h r=%b expected v=1 d=a r=1",
                               out_valid_o, out_data_o, in_ready_o);
        end
        in_data_i = 32'hB;
        tick();
        n_checks++;
        if (in_ready_o !== 1'b0 || out_data_o !== 32'hA) begin
            n_fail++; $display("FAIL bp_full: got r=%b d=%h expected r=0 d=a", in_ready_o, out_data_o);
        end
`ifdef PRIM_SKID_SLICE_OCC_EN
        n_checks++;
        if (occ_o !== 2'd2) begin
            n_fail++; $display("FAIL bp_occ_full: got %0d expected 2", occ_o);
        end
`endif
        in_data_i = 32'hC;  // held by upstream while in_ready_o=0
        tick();
        n_checks++;
        if (out_data_o !== 32'hA || in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold: got d=%h r=%b expected d=a r=0", out_data_o, in_ready_o);
        end
        out_ready_i = 1'b1;
        tick();
        n_checks++;
        if (out_data_o !== 32'hB || out_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_b: got v=%b d=%h r=%b expected v=1 d=b r=1",
                               out_valid_o, out_data_o, in_ready_o);
        end
`ifdef PRIM_SKID_SLICE_OCC_EN
        n_checks++;
        if (occ_o !== 2'd1) begin
            n_fail++; $display("FAIL bp_occ_one: got %0d expected 1", occ_o);
        end
`endif
        tick();
        n_checks++;
        if (out_data_o !== 32'hC || out_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_c: got v=%b d=%h expected v=1 d=c", out_valid_o, out_data_o);
        end
        in_valid_i = 1'b0;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid_o);
        end
    endtask

    task automatic test_simultaneous();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'd5;
        tick();
        out_ready_i = 1'b1;
        in_data_i   = 32'd6;
        tick();
        n_checks++;
        if (out_data_o !== 32'd6 || out_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL simul: got v=%b d=%h r=%b expected v=1 d=6 r=1",
                               out_valid_o, out_data_o, in_ready_o);
        end
`ifdef PRIM_SKID_SLICE_OCC_EN
        n_checks++;
        if (occ_o !== 2'd1) begin
            n_fail++; $display("FAIL simul_occ: got %0d expected 1", occ_o);
        end
`endif
        in_valid_i = 1'b0;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL simul_drain: got %b expected 0", out_valid_o);
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'd7;
        tick();
        in_data_i = 32'd8;
        tick();
        n_checks++;
        if (in_ready_o !== 1'b0 || out_data_o !== 32'd7) begin
            n_fail++; $display("FAIL flush_setup: got r=%b d=%h expected r=0 d=7", in_ready_o, out_data_o);
        end
        flush_i   = 1'b1;
        in_data_i = 32'd9;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_state: got v=%b r=%b expected v=0 r=1", out_valid_o, in_ready_o);
        end
`ifdef PRIM_SKID_SLICE_OCC_EN
        n_checks++;
        if (occ_o !== 2'd0) begin
            n_fail++; $display("FAIL flush_occ: got %0d expected 0", occ_o);
        end
`endif
        out_ready_i = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (out_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL flush_no_leak[%0d]: got v=%b d=%h expected v=0", k, out_valid_o, out_data_o);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h11;
        tick();
        in_data_i = 32'h22;
        tick();
        in_valid_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL areset_setup: got r=%b expected 0", in_ready_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_data_o !== RV) begin
            n_fail++; $display("FAIL areset_immediate: got v=%b r=%b d=%h expected v=0 r=1 d=%h",
                               out_valid_o, in_ready_o, out_data_o, RV);
        end
`ifdef PRIM_SKID_SLICE_OCC_EN
        n_checks++;
        if (occ_o !== 2'd0) begin
            n_fail++; $display("FAIL areset_occ: got %0d expected 0", occ_o);
        end
`endif
        tick();
        rst_ni = 1'b1;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== RV) begin
            n_fail++; $display("FAIL areset_after: got v=%b d=%h expected v=0 d=%h", out_valid_o, out_data_o, RV);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prim_skid_slice.md
Name: prim_skid_slice

Overview:
- Two-entry valid/ready register slice (skid buffer) that breaks both the forward path (valid/data) and the reverse path (ready) between a producer and a consumer.
- It is the backpressure-aware counterpart to a plain data flop: data moves forward, ready moves backward, and both are registered.
- Instantiated at pipeline boundaries (e.g. between the fetch and decode request interfaces) to close timing without losing or duplicating transfers.

Parameters:
- Width, 32, data path width in bits (>=1).
- ResetValue, '0 (Width bits), reset value of both internal data registers and therefore of out_data_o.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- flush_i  input  1  synchronous flush; discards all held entries
- in_valid_i  input  1  upstream data valid
- in_ready_o  output  1  slice can accept data; registered
- in_data_i  input  Width  upstream data
- out_valid_o  output  1  slice holds data for downstream; registered
- out_ready_i  input  1  downstream accepts data
- out_data_o  output  Width  data presented downstream; registered
- occ_o  output  2  entry count 0..2; present only with PRIM_SKID_SLICE_OCC_EN

Behaviour:
- Clock and reset: clk_i is the clock; rst_ni is the reset, asynchronous, active-low.
- Transfers: in_xfer = in_valid_i & in_ready_o; out_xfer = out_valid_o & out_ready_i.
- Storage: main register (drives out_data_o) and skid register.
- State machine: EMPTY, ONE, FULL.
- Derived outputs (decoded from state flops, no combinational path from any input):
  - out_valid_o = (state != EMPTY)
  - in_ready_o = (state != FULL)
- Reset: state=EMPTY; main=skid=ResetValue. So out_valid_o=0, in_ready_o=1, out_data_o=ResetValue, occ_o=0. Upstream must not present transfers while rst_ni is low; in_data_i is ignored during reset.
- Transitions (evaluated at posedge clk_i):
  - EMPTY: in_xfer -> ONE, main<=in_data_i. Otherwise stay.
  - ONE, in_xfer & out_xfer -> ONE, main<=in_data_i.
  - ONE, in_xfer only -> FULL, skid<=in_data_i; main unchanged.
  - ONE, out_xfer only -> EMPTY.
  - ONE, neither -> stay.
  - FULL (in_ready_o=0, so no in_xfer): out_xfer -> ONE, main<=skid. Otherwise stay.
- Latency: data accepted in cycle N appears on out_data_o with out_valid_o=1 in cycle N+1 when the slice was empty. Throughput is 1 transfer/cycle sustained when out_ready_i=1.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Output stability: once out_valid_o=1, out_valid_o and out_data_o hold until out_xfer or flush_i. Deasserting out_ready_i never alters presented data.
- The skid register absorbs exactly one beat when out_ready_i drops while in_ready_o was already 1. No beat is ever lost or duplicated.
- flush_i: highest priority.
  - state<=EMPTY next cycle; any in_xfer or out_xfer in the same cycle is discarded on the slice side.
  - The downstream consumer still sees its beat as taken if out_ready_i=1.
  - Data registers are unchanged by flush (stale contents are don't-care while out_valid_o=0).
- out_data_o while EMPTY: holds the last main value (ResetValue after reset). The consumer must qualify it with out_valid_o.
- Reset asserted mid-operation: all state clears immediately (asynchronous); held entries are lost by design.

Optional Feature:
- Macro: PRIM_SKID_SLICE_OCC_EN
- Defined: port occ_o[1:0] exists, driven from state: EMPTY=0, ONE=1, FULL=2. Registered; reset 0; follows flush to 0 in the next cycle.
- Undefined: port occ_o is absent; no extra logic. All other behaviour is identical.

Test Plan:
- Reset then idle, Width=32, ResetValue=32'hDEAD_BEEF: out_valid_o=0, in_ready_o=1, out_data_o=32'hDEAD_BEEF, occ_o=0.
- Streaming, out_ready_i=1, inputs 1,2,3,4 on consecutive cycles: outputs 1,2,3,4 on consecutive cycles, each 1 cycle later. in_ready_o stays 1; occ_o=1 throughout.
- Backpressure: push A,B,C back-to-back with out_ready_i=0:
  - A lands in main, B in skid, in_ready_o=0 the cycle after B, C is held by upstream.
  - Raise out_ready_i: outputs A,B,C in order, occ_o 2->1->... with no loss.
- Simultaneous in/out in ONE, main=5, push 6 with out_ready_i=1: next cycle out_data_o=6, state remains ONE, in_ready_o=1.
- Flush while FULL (main=7, skid=8), flush_i=1 with in_valid_i=1: next cycle out_valid_o=0, in_ready_o=1, occ_o=0. Neither 7, 8 nor the input beat appears later.
- Async reset while FULL, mid-cycle rst_ni low: out_valid_o drops immediately, out_data_o=ResetValue, in_ready_o=1 before the next clock edge.
